// File: rtl/laser_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : laser_frame_ctrl_pkg
// Description : Shared constants, state encodings and helpers for the
//               laser-spot frame sequencer and its result slot.
// Contents    : c_COORD_W    - width of the pixel x/y counters
//               c_XY_W       - width of a packed {x, y} coordinate
//               c_DEF_THRESH - red threshold applied after reset
//               c_ST_*       - sequencer state encodings
//               result_t     - one published frame result
//               xy_pack()    - pack x and y into {x, y}
//               coord_zext() - zero-extend a coordinate to a 32-bit bus
// Revision    : 1.0 - initial release
// ============================================================================
package laser_frame_ctrl_pkg;

   localparam int unsigned c_COORD_W = 16;
   localparam int unsigned c_XY_W    = 2 * c_COORD_W;

   localparam logic [7:0] c_DEF_THRESH = 8'd64;

   localparam logic [1:0] c_ST_IDLE      = 2'd0;
   localparam logic [1:0] c_ST_WAIT_SOF  = 2'd1;
   localparam logic [1:0] c_ST_SCAN      = 2'd2;
   localparam logic [1:0] c_ST_EOF_FLUSH = 2'd3;

   typedef struct packed {
      logic              found;
      logic [c_XY_W-1:0] xy;
   } result_t;

   function automatic logic [c_XY_W-1:0] xy_pack(input logic [c_COORD_W-1:0] x,
                                                 input logic [c_COORD_W-1:0] y);
      return {x, y};
   endfunction

   function automatic logic [31:0] coord_zext(input logic [c_COORD_W-1:0] c);
      return {{(32 - c_COORD_W){1'b0}}, c};
   endfunction

endpackage
`default_nettype wire

// File: rtl/laser_result_slot.sv
`default_nettype none
// ============================================================================
// Module      : laser_result_slot
// Description : Single-entry result register with valid/ready hand-off to
//               downstream, overwrite-on-publish with sticky overrun flag,
//               and wrapping published-frame / missed-frame counters.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_publish           - load a new result this cycle
//               i_found / i_xy      - result being published
//               i_ready             - downstream accepts the held result
//               o_valid             - a result is held
//               o_found / o_xy      - held result
//               o_frame_cnt         - results published (wraps)
//               o_miss_cnt          - published results with no spot (wraps)
//               o_overrun           - sticky: unconsumed result overwritten
// Revision    : 1.0 - initial release
// ============================================================================
module laser_result_slot
   import laser_frame_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_publish,
   input  logic              i_found,
   input  logic [c_XY_W-1:0] i_xy,
   input  logic              i_ready,
   output logic              o_valid,
   output logic              o_found,
   output logic [c_XY_W-1:0] o_xy,
   output logic [15:0]       o_frame_cnt,
   output logic [15:0]       o_miss_cnt,
   output logic              o_overrun
);

   logic        r_valid;
   result_t     r_res;
   logic [15:0] r_frame_cnt;
   logic [15:0] r_miss_cnt;
   logic        r_overrun;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_res       <= '0;
         r_frame_cnt <= '0;
         r_miss_cnt  <= '0;
         r_overrun   <= 1'b0;
      end else begin
         if (i_publish) begin
            // A publish wins over a same-cycle consume: the old result is
            // gone either way, but it only counts as lost if nobody took it.
            r_res.found <= i_found;
            r_res.xy    <= i_xy;
            r_valid     <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            if (!i_found) begin
               r_miss_cnt <= r_miss_cnt + 16'd1;
            end
            if (r_valid && !i_ready) begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_valid     = r_valid;
   assign o_found     = r_res.found;
   assign o_xy        = r_res.xy;
   assign o_frame_cnt = r_frame_cnt;
   assign o_miss_cnt  = r_miss_cnt;
   assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: rtl/laser_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : laser_frame_ctrl
// Description : Frame-level sequencer for the laser-spot detector. Tracks the
//               pixel position of the incoming video stream, drives the
//               detector enable / synchronous reset / red threshold, captures
//               the spot coordinate on a hit and publishes one result per
//               frame through laser_result_slot.
// Ports       : clk, reset                 - clock, sync active-high reset
//               enable                     - software run enable
//               thresh_in, thresh_wr       - pending threshold write
//               pix_valid/pix_sof/pix_eol  - video stream framing
//               det_hit, det_laser_xy      - detector status and coordinate
//               det_en, det_reset_n        - detector control
//               det_threshold              - threshold held for a frame
//               x_out, y_out               - position of the current pixel
//               res_valid/res_ready        - result hand-off
//               res_xy, res_found          - published result
//               frame_cnt, miss_cnt        - wrapping frame bookkeeping
//               overrun, sync_err          - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module laser_frame_ctrl
   import laser_frame_ctrl_pkg::*;
#(
   parameter int unsigned FRAME_W    = 640,
   parameter int unsigned FRAME_H    = 480,
   parameter logic [7:0]  DEF_THRESH = c_DEF_THRESH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [7:0]  thresh_in,
   input  logic        thresh_wr,
   input  logic        pix_valid,
   input  logic        pix_sof,
   input  logic        pix_eol,
   input  logic        det_hit,
   input  logic [31:0] det_laser_xy,
   output logic        det_en,
   output logic        det_reset_n,
   output logic [7:0]  det_threshold,
   output logic [31:0] x_out,
   output logic [31:0] y_out,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_xy,
   output logic        res_found,
   output logic [15:0] frame_cnt,
   output logic [15:0] miss_cnt,
   output logic        overrun,
   output logic        sync_err
);

   // The line length is never checked at run time (pix_eol is authoritative);
   // FRAME_W only has to fit the coordinate counter.
   if (FRAME_W < 1 || FRAME_W > (1 << c_COORD_W)) begin : g_bad_frame_w
      $error("laser_frame_ctrl: FRAME_W does not fit the coordinate counter");
   end
   if (FRAME_H < 1 || FRAME_H >= (1 << c_COORD_W)) begin : g_bad_frame_h
      $error("laser_frame_ctrl: FRAME_H does not fit the coordinate counter");
   end

   localparam logic [c_COORD_W-1:0] c_LAST_Y = c_COORD_W'(FRAME_H - 1);

   logic [1:0]           r_state;
   logic [1:0]           w_state_nxt;
   logic [c_COORD_W-1:0] r_x;
   logic [c_COORD_W-1:0] r_y;
   logic [c_COORD_W-1:0] w_x_adv;
   logic [c_COORD_W-1:0] w_y_adv;
   logic                 w_last;
   logic                 w_accept;
   logic                 w_pix;
   logic                 w_scan_hold;
   logic                 w_scan_sof;
   logic                 w_publish;
   logic                 w_unarmed;
   logic [7:0]           r_pend;
   logic [7:0]           r_thresh;
   logic                 r_hit_d1;
   logic                 r_found;
   logic [c_XY_W-1:0]    r_cap;
   logic                 r_sync_err;

   // First pixel of a frame, taken only while armed and enabled.
   assign w_accept    = (r_state == c_ST_WAIT_SOF) && enable && pix_valid && pix_sof;
   // An ordinary in-frame pixel; a SOF seen mid-frame is not processed.
   assign w_pix       = (r_state == c_ST_SCAN) && enable && pix_valid && !pix_sof;
   assign w_scan_hold = (r_state == c_ST_SCAN) && enable && !pix_valid;
   assign w_scan_sof  = (r_state == c_ST_SCAN) && enable && pix_valid && pix_sof;
   assign w_publish   = (r_state == c_ST_EOF_FLUSH);
   assign w_unarmed   = (r_state == c_ST_IDLE) || (r_state == c_ST_WAIT_SOF);

   // Position of the pixel after the one on the bus. The accept cycle is at
   // (0,0) because x/y sit at zero while waiting, so one adder serves both.
   assign w_x_adv = pix_eol ? '0 : r_x + 1'b1;
   assign w_y_adv = pix_eol ? r_y + 1'b1 : r_y;
   assign w_last  = pix_eol && (r_y == c_LAST_Y);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (enable) begin
               w_state_nxt = c_ST_WAIT_SOF;
            end
         end
         c_ST_WAIT_SOF: begin
            if (!enable) begin
               w_state_nxt = c_ST_IDLE;
            end else if (w_accept) begin
               w_state_nxt = w_last ? c_ST_EOF_FLUSH : c_ST_SCAN;
            end
         end
         c_ST_SCAN: begin
            if (!enable) begin
               w_state_nxt = c_ST_IDLE;
            end else if (w_scan_sof) begin
               w_state_nxt = c_ST_WAIT_SOF;
            end else if (w_pix && w_last) begin
               w_state_nxt = c_ST_EOF_FLUSH;
            end
         end
         c_ST_EOF_FLUSH: begin
            w_state_nxt = enable ? c_ST_WAIT_SOF : c_ST_IDLE;
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= c_ST_IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_pend     <= DEF_THRESH;
         r_thresh   <= DEF_THRESH;
         r_hit_d1   <= 1'b0;
         r_found    <= 1'b0;
         r_cap      <= '0;
         r_sync_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (thresh_wr) begin
            r_pend <= thresh_in;
         end
         // The applied threshold tracks the pending one only between frames,
         // and is frozen from the SOF pixel on.
         if (w_unarmed && !w_accept) begin
            r_thresh <= r_pend;
         end

         if (w_accept || w_pix) begin
            r_x <= w_x_adv;
            r_y <= w_y_adv;
         end else if (!w_scan_hold) begin
            r_x <= '0;
            r_y <= '0;
         end

         // The detector presents its run centre one cycle after raising
         // det_hit, so capture on the delayed flag. Hits after the EOF pixel
         // land outside SCAN and are ignored.
         r_hit_d1 <= (r_state == c_ST_SCAN) ? det_hit : 1'b0;
         if ((r_state == c_ST_SCAN) && r_hit_d1 && !r_found) begin
            r_cap   <= det_laser_xy;
            r_found <= 1'b1;
         end else if (w_unarmed) begin
            r_cap   <= '0;
            r_found <= 1'b0;
         end

         if ((r_state == c_ST_SCAN) && (!enable || w_scan_sof)) begin
            r_sync_err <= 1'b1;
         end
      end
   end

   laser_result_slot u_slot (
      .clk         (clk),
      .rst         (reset),
      .i_publish   (w_publish),
      .i_found     (r_found),
      .i_xy        (r_found ? r_cap : xy_pack('0, '0)),
      .i_ready     (res_ready),
      .o_valid     (res_valid),
      .o_found     (res_found),
      .o_xy        (res_xy),
      .o_frame_cnt (frame_cnt),
      .o_miss_cnt  (miss_cnt),
      .o_overrun   (overrun)
   );

   assign det_reset_n   = (r_state == c_ST_SCAN) || w_accept;
   assign det_en        = w_accept || w_pix;
   assign det_threshold = r_thresh;
   assign x_out         = coord_zext(r_x);
   assign y_out         = coord_zext(r_y);
   assign sync_err      = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_laser_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_laser_frame_ctrl
// Description : Self-checking bench for laser_frame_ctrl (8x4 frames). A
//               behavioural model of the frame sequencer is compared against
//               every DUT output on each falling edge; directed scenarios add
//               hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_laser_frame_ctrl;

   localparam int c_W = 8;
   localparam int c_H = 4;
   localparam int c_NPIX = c_W * c_H;

   localparam int M_OFF   = 0;
   localparam int M_WAIT  = 1;
   localparam int M_FRAME = 2;
   localparam int M_FLUSH = 3;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [7:0]  thresh_in;
   logic        thresh_wr;
   logic        pix_valid;
   logic        pix_sof;
   logic        pix_eol;
   logic        det_hit;
   logic [31:0] det_laser_xy;
   logic        det_en;
   logic        det_reset_n;
   logic [7:0]  det_threshold;
   logic [31:0] x_out;
   logic [31:0] y_out;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_xy;
   logic        res_found;
   logic [15:0] frame_cnt;
   logic [15:0] miss_cnt;
   logic        overrun;
   logic        sync_err;

   int n_chk;
   int n_fail;
   bit chk_on;

   laser_frame_ctrl #(
      .FRAME_W    (c_W),
      .FRAME_H    (c_H),
      .DEF_THRESH (8'h40)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .thresh_in     (thresh_in),
      .thresh_wr     (thresh_wr),
      .pix_valid     (pix_valid),
      .pix_sof       (pix_sof),
      .pix_eol       (pix_eol),
      .det_hit       (det_hit),
      .det_laser_xy  (det_laser_xy),
      .det_en        (det_en),
      .det_reset_n   (det_reset_n),
      .det_threshold (det_threshold),
      .x_out         (x_out),
      .y_out         (y_out),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_xy        (res_xy),
      .res_found     (res_found),
      .frame_cnt     (frame_cnt),
      .miss_cnt      (miss_cnt),
      .overrun       (overrun),
      .sync_err      (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: what the sequencer must present, frame by frame.
   // ------------------------------------------------------------------
   int          m_mode;
   int          m_x, m_y;
   logic [7:0]  m_pend, m_thr;
   bit          m_hprev, m_found;
   logic [31:0] m_cap;
   bit          m_valid, m_fnd, m_ovr, m_serr;
   logic [31:0] m_xy;
   logic [15:0] m_frames, m_misses;
   bit          m_acc, m_pix;

   task automatic model_reset();
      m_mode = M_OFF; m_x = 0; m_y = 0;
      m_pend = 8'h40; m_thr = 8'h40;
      m_hprev = 0; m_found = 0; m_cap = '0;
      m_valid = 0; m_fnd = 0; m_xy = '0; m_ovr = 0; m_serr = 0;
      m_frames = '0; m_misses = '0;
   endtask

   task automatic model_advance();
      // threshold: follows the pending value between frames only
      if ((m_mode == M_OFF || m_mode == M_WAIT) && !m_acc) m_thr = m_pend;
      if (thresh_wr) m_pend = thresh_in;
      // spot: taken one in-frame cycle after det_hit was first seen
      if (m_mode == M_FRAME && m_hprev && !m_found) begin
         m_found = 1;
         m_cap   = det_laser_xy;
      end
      m_hprev = (m_mode == M_FRAME) && det_hit;
      // one result per completed frame
      if (m_mode == M_FLUSH) begin
         if (m_valid && !res_ready) m_ovr = 1;
         m_valid = 1;
         m_fnd   = m_found;
         m_xy    = m_found ? m_cap : 32'h0;
         m_frames++;
         if (!m_found) m_misses++;
      end else if (m_valid && res_ready) begin
         m_valid = 0;
      end
      case (m_mode)
         M_OFF: begin
            m_x = 0; m_y = 0;
            if (enable) m_mode = M_WAIT;
         end
         M_WAIT: begin
            if (!enable) m_mode = M_OFF;
            else if (m_acc) begin
               m_x = 1; m_y = 0; m_mode = M_FRAME;
            end
         end
         M_FRAME: begin
            if (!enable) begin
               m_serr = 1; m_mode = M_OFF; m_x = 0; m_y = 0;
            end else if (pix_valid && pix_sof) begin
               m_serr = 1; m_mode = M_WAIT; m_x = 0; m_y = 0;
            end else if (m_pix) begin
               if (pix_eol) begin
                  m_x = 0; m_y++;
                  if (m_y == c_H) m_mode = M_FLUSH;
               end else begin
                  m_x++;
               end
            end
         end
         default: begin
            m_x = 0; m_y = 0;
            m_mode = enable ? M_WAIT : M_OFF;
         end
      endcase
      if (m_mode == M_OFF || m_mode == M_WAIT) begin
         m_found = 0; m_cap = '0;
      end
   endtask

   // Compare process: outputs are checked mid-cycle, then the model steps
   // over the coming rising edge using the (stable) inputs of this cycle.
   always @(negedge clk) begin
      if (reset) begin
         model_reset();
      end else begin
         m_acc = (m_mode == M_WAIT) && enable && pix_valid && pix_sof;
         m_pix = (m_mode == M_FRAME) && enable && pix_valid && !pix_sof;
         if (chk_on) begin
            chk("det_en",        32'(det_en),        32'(m_acc || m_pix));
            chk("det_reset_n",   32'(det_reset_n),   32'((m_mode == M_FRAME) || m_acc));
            chk("det_threshold", 32'(det_threshold), 32'(m_thr));
            chk("x_out",         x_out,              32'(m_x));
            chk("y_out",         y_out,              32'(m_y));
            chk("res_valid",     32'(res_valid),     32'(m_valid));
            chk("res_xy",        res_xy,             m_xy);
            chk("res_found",     32'(res_found),     32'(m_fnd));
            chk("frame_cnt",     32'(frame_cnt),     32'(m_frames));
            chk("miss_cnt",      32'(miss_cnt),      32'(m_misses));
            chk("overrun",       32'(overrun),       32'(m_ovr));
            chk("sync_err",      32'(sync_err),      32'(m_serr));
         end
         model_advance();
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic rdy);
      pix_valid = 0; pix_sof = 0; pix_eol = 0; det_hit = 0; thresh_wr = 0;
      res_ready = rdy;
      repeat (n) step();
      res_ready = 0;
   endtask

   // One frame of c_NPIX pixels. hit_idx: det_hit rises after that pixel
   // (-1: never). ready_mode 0: never ready, 1: random, 2: only on the
   // publish cycle. abort_kind 1: SOF, 2: enable drop, 3: reset, applied on
   // pixel abort_idx; the task then returns with that cycle just clocked.
   task automatic drive_frame(input int gap_pct, input int hit_idx, input logic [31:0] xy,
                              input int ready_mode, input int wr_idx,
                              input int abort_idx, input int abort_kind);
      int  p;
      bit  hit_on;
      p = 0; hit_on = 0;
      det_laser_xy = xy;
      while (p < c_NPIX) begin
         thresh_wr = 0;
         if (p > 0 && $urandom_range(99) < gap_pct) begin
            pix_valid = 0; pix_sof = 0; pix_eol = 0;
         end else begin
            pix_valid = 1;
            pix_sof   = (p == 0);
            pix_eol   = ((p % c_W) == c_W - 1);
            if (p == wr_idx) begin
               thresh_wr = 1; thresh_in = 8'h20;
            end
            if (p == abort_idx) begin
               case (abort_kind)
                  1: pix_sof = 1;
                  2: enable = 0;
                  default: reset = 1;
               endcase
            end
         end
         det_hit   = hit_on;
         res_ready = (ready_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
         if (p == 0) begin
            #1;
            chk("sof_accept_rstn", 32'(det_reset_n), 32'h1);
            chk("sof_accept_en",   32'(det_en),      32'h1);
         end
         step();
         thresh_wr = 0;
         if (pix_valid) begin
            if (p == abort_idx) return;
            if (p == hit_idx) hit_on = 1;
            p++;
         end
      end
      pix_valid = 0; pix_sof = 0; pix_eol = 0;
      det_hit   = hit_on;
      res_ready = (ready_mode == 2) ? 1'b1 :
                  (ready_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
      chk("flush_rstn", 32'(det_reset_n), 32'h0);
      step();
      det_hit   = 0;
      res_ready = 0;
   endtask

   initial begin
      int hidx;
      chk_on = 0; n_chk = 0; n_fail = 0;
      reset = 1; enable = 0; thresh_in = 0; thresh_wr = 0;
      pix_valid = 0; pix_sof = 0; pix_eol = 0;
      det_hit = 0; det_laser_xy = 0; res_ready = 0;
      repeat (3) step();
      reset = 0; chk_on = 1;
      chk("rst_det_reset_n", 32'(det_reset_n),   32'h0);
      chk("rst_threshold",   32'(det_threshold), 32'h40);
      chk("rst_frame_cnt",   32'(frame_cnt),     32'h0);
      chk("rst_res_valid",   32'(res_valid),     32'h0);

      // spot found at the run centre reported after pixel (5,2)
      enable = 1; idle(2, 0);
      drive_frame(0, 2 * c_W + 5, 32'h0003_0002, 0, -1, -1, 0);
      chk("a_res_xy",    res_xy,           32'h0003_0002);
      chk("a_model_xy",  m_xy,             32'h0003_0002);
      chk("a_res_found", 32'(res_found),   32'h1);
      chk("a_frame_cnt", 32'(frame_cnt),   32'h1);
      chk("a_miss_cnt",  32'(miss_cnt),    32'h0);
      chk("a_res_valid", 32'(res_valid),   32'h1);

      // miss frame overwriting the unconsumed result
      idle(2, 0);
      drive_frame(0, -1, 32'h1234_5678, 0, -1, -1, 0);
      chk("b_overrun",   32'(overrun),   32'h1);
      chk("b_res_found", 32'(res_found), 32'h0);
      chk("b_res_xy",    res_xy,         32'h0);
      chk("b_miss_cnt",  32'(miss_cnt),  32'h1);
      chk("b_frame_cnt", 32'(frame_cnt), 32'h2);
      idle(1, 1);
      chk("b_consumed",  32'(res_valid), 32'h0);

      // publish coinciding with a handshake
      reset = 1; step(); reset = 0;
      idle(2, 0);
      drive_frame(0, -1, 32'h0, 0, -1, -1, 0);
      idle(2, 0);
      drive_frame(0, 5, 32'h0001_0000, 2, -1, -1, 0);
      chk("d_overrun",   32'(overrun),   32'h0);
      chk("d_res_valid", 32'(res_valid), 32'h1);
      chk("d_frame_cnt", 32'(frame_cnt), 32'h2);

      // threshold written mid-frame applies only from the next wait
      idle(2, 0);
      drive_frame(0, -1, 32'h0, 1, 12, -1, 0);
      chk("e_thr_frozen",  32'(det_threshold), 32'h40);
      idle(1, 0);
      chk("e_thr_applied", 32'(det_threshold), 32'h20);
      idle(1, 0);
      drive_frame(0, 9, 32'h0004_0001, 1, -1, -1, 0);

      // SOF at (3,1) mid-frame
      idle(2, 0);
      drive_frame(0, -1, 32'h0, 1, -1, c_W + 3, 1);
      chk("g_sync_err",  32'(sync_err),  32'h1);
      chk("g_frame_cnt", 32'(frame_cnt), 32'h4);
      idle(2, 0);
      drive_frame(25, 3, 32'h0000_0007, 1, -1, -1, 0);
      chk("h_frame_cnt", 32'(frame_cnt), 32'h5);

      // enable dropped mid-frame
      idle(2, 0);
      drive_frame(0, -1, 32'h0, 1, -1, 13, 2);
      chk("i_det_en",    32'(det_en),      32'h0);
      chk("i_rstn",      32'(det_reset_n), 32'h0);
      chk("i_frame_cnt", 32'(frame_cnt),   32'h5);
      idle(1, 0);
      enable = 1;
      idle(2, 0);

      // random frames with 50% pixel gaps
      for (int f = 0; f < 6; f++) begin
         hidx = int'($urandom_range(40));
         if (hidx >= c_NPIX) hidx = -1;
         drive_frame(50, hidx, $urandom, 1, -1, -1, 0);
         idle(int'($urandom_range(4, 2)), 1'($urandom_range(1)));
      end

      // reset in the middle of a frame
      drive_frame(30, 4, 32'h0005_0005, 1, 7, 20, 3);
      chk("k_frame_cnt", 32'(frame_cnt),     32'h0);
      chk("k_res_valid", 32'(res_valid),     32'h0);
      chk("k_sync_err",  32'(sync_err),      32'h0);
      chk("k_overrun",   32'(overrun),       32'h0);
      chk("k_threshold", 32'(det_threshold), 32'h40);
      chk("k_x_out",     x_out,              32'h0);
      chk("k_rstn",      32'(det_reset_n),   32'h0);
      reset = 0;
      idle(2, 0);
      drive_frame(0, -1, 32'h0, 1, -1, -1, 0);
      chk("l_frame_cnt", 32'(frame_cnt), 32'h1);
      chk("l_miss_cnt",  32'(miss_cnt),  32'h1);
      idle(2, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/laser_frame_ctrl.md
Name: laser_frame_ctrl

Overview:
- Frame-level sequencer for the laser-spot detector in the image_processing IP.
- Tracks pixel x/y from the video stream and drives the detector's enable, synchronous reset and red threshold.
- Resets the detector at every frame boundary and captures the spot coordinate when a hit occurs.
- Publishes one result per frame to downstream (turret/register logic) over a valid/ready handshake, with frame, miss and error bookkeeping.

Parameters:
- FRAME_W, 640: active pixels per line.
- FRAME_H, 480: active lines per frame.
- DEF_THRESH, 8'd64: red threshold applied after reset.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  software run enable.
- thresh_in  in  8  new red threshold.
- thresh_wr  in  1  one-cycle write strobe for thresh_in.
- pix_valid  in  1  pixel present on the shared data bus this cycle.
- pix_sof  in  1  first pixel of frame; qualified by pix_valid.
- pix_eol  in  1  last pixel of line; qualified by pix_valid.
- det_hit  in  1  detector run-complete flag; sticky until detector reset.
- det_laser_xy  in  32  detector coordinate output, {x[15:0], y[15:0]}.
- det_en  out  1  detector enable.
- det_reset_n  out  1  detector synchronous reset, active low.
- det_threshold  out  8  threshold applied to the detector.
- x_out  out  32  x of the current pixel, zero-extended 16-bit counter.
- y_out  out  32  y of the current pixel, zero-extended 16-bit counter.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_xy  out  32  captured spot coordinate; 0 when not found.
- res_found  out  1  a spot was captured this frame.
- frame_cnt  out  16  frames published; wraps.
- miss_cnt  out  16  published frames with no spot; wraps.
- overrun  out  1  sticky: an unconsumed result was overwritten.
- sync_err  out  1  sticky: SOF mid-frame, or frame aborted.

Behaviour:
- Reset values:
  - State IDLE.
  - All counters, res_*, overrun, sync_err, x/y = 0.
  - det_threshold = pending threshold = DEF_THRESH.
  - det_reset_n = 0.
- Threshold register:
  - thresh_wr loads the pending register in any state.
  - det_threshold <= pending every cycle in IDLE/WAIT_SOF, except the SOF-accept cycle.
  - det_threshold is frozen in SCAN/EOF_FLUSH, so it is constant for a whole frame.
- States:
  - IDLE: enable=0. det_reset_n=0, det_en=0. Goes to WAIT_SOF when enable=1.
  - WAIT_SOF: x=y=0, det_reset_n=0.
    - On pix_valid&&pix_sof, the accept cycle drives det_reset_n=1 and det_en=1, so that pixel is processed at (0,0). Next state SCAN, x=1.
    - Goes to IDLE if enable=0.
  - SCAN: det_reset_n=1, det_en=pix_valid.
    - Each valid pixel: x++.
    - Valid with pix_eol: x<=0, y++.
    - Valid with pix_eol and y==FRAME_H-1: go to EOF_FLUSH.
  - EOF_FLUSH: exactly one cycle. det_reset_n=0. Publish the result. Next state WAIT_SOF, or IDLE if enable=0.
- x_out/y_out are registered counters; they equal the coordinate of the pixel presented in the same cycle. The line counter does not check FRAME_W; pix_eol is authoritative.
- Hit capture:
  - hit_d1 <= det_hit, forced 0 outside SCAN.
  - In SCAN, on the first cycle where hit_d1=1 and found_int=0: cap_xy <= det_laser_xy and found_int <= 1. This is the cycle the detector presents the run centre.
  - At most one capture per frame.
  - Captures on or before the EOF pixel cycle count toward the frame. Later hits are dropped.
  - found_int and cap_xy clear on entry to WAIT_SOF.
- Publish (EOF_FLUSH):
  - res_xy <= found_int ? cap_xy : 0.
  - res_found <= found_int.
  - res_valid <= 1.
  - frame_cnt++.
  - miss_cnt++ when found_int=0.
- Handshake:
  - res_valid holds until res_valid&&res_ready, then clears the next cycle.
  - Publish while res_valid=1 and res_ready=0: overwrite and set overrun.
  - Publish in the same cycle as a handshake: load the new result, res_valid stays 1, no overrun.
- Boundary conditions:
  - SOF in SCAN: frame is discarded and the SOF pixel is dropped. Set sync_err, go to WAIT_SOF (detector reset). No publish, no counter change.
  - enable falling in SCAN: abort to IDLE, set sync_err, no publish.
  - pix_valid=0 cycles: counters hold; det_en=0.
  - Counter wrap: frame_cnt and miss_cnt wrap 0xFFFF→0.
  - reset mid-frame: everything returns to reset values immediately.

Decomposition:
- Shared package/header (global.vh): state encodings IDLE/WAIT_SOF/SCAN/EOF_FLUSH, coordinate width 16, XY packing macro {x,y}, DEF_THRESH.
- One natural sub-module: laser_result_slot, the result register with valid/ready, overwrite, overrun and the frame/miss counters.
- The FSM, pixel counters and capture logic stay in the top.

Test Plan:
- FRAME_W=8, FRAME_H=4, continuous valid, det_hit rises after pixel (5,2) with det_laser_xy=0x0003_0002 -> one EOF_FLUSH publish: res_xy=0x00030002, res_found=1, frame_cnt=1, miss_cnt=0.
- Frame with det_hit never asserted -> res_found=0, res_xy=0, miss_cnt=1. det_reset_n=0 in EOF_FLUSH and WAIT_SOF, =1 on the SOF accept cycle.
- res_ready held 0 across two frames -> second result overwrites, overrun=1. Repeat with res_ready=1 exactly on the publish cycle -> overrun stays 0, res_valid stays 1.
- thresh_wr=0x20 mid-SCAN -> det_threshold stays 0x40 until the next WAIT_SOF, then 0x20 before the next SOF accept.
- pix_sof at (3,1) mid-SCAN -> sync_err=1, no publish, the next SOF restarts at (0,0). enable dropped mid-frame -> IDLE, frame_cnt unchanged.
- Random pix_valid gaps (50%) -> x_out/y_out advance only on valid pixels, det_en==pix_valid in SCAN. Reset asserted mid-frame -> all outputs return to reset values the next cycle.
